// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the RX and future TX blocks
package uart_pkg;
    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 436;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte output stream of the UART receiver with status flags
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (output data, valid, frame_err, overrun, busy, input ready);
    modport slave  (input data, valid, frame_err, overrun, busy, output ready);
endinterface

// File: rtl/uart_rx_sync_ff.sv
// sync_ff: multi-stage synchroniser for an asynchronous input, resets to 1
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] ff_q;

    // shift the raw input through the chain; reset to the idle-high level
    always_ff @(posedge clk_i) begin
        if (!rst_ni) ff_q <= '1;
        else         ff_q <= {ff_q[STAGES-2:0], d_i};
    end

    assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and valid/ready byte output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    uart_rx_if.master   out_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rxs;
    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] sr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx_i),
        .q_o    (rxs)
    );

    // frame FSM: bit timing, shift register, delivery into the holding register and flag pulses
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && out_if.ready) valid_q <= 1'b0;
            cnt_q <= (state_q == IDLE) ? '0 : cnt_q + CW'(1);
            case (state_q)
                IDLE: if (!rxs) begin
                    state_q <= START;
                    cnt_q   <= '0;
                end
                START: if (cnt_q == HALF) begin
                    state_q <= rxs ? IDLE : DATA;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
                DATA: if (cnt_q == LAST) begin
                    sr_q  <= {rxs, sr_q[DATA_BITS-1:1]};
                    idx_q <= idx_q + IW'(1);
                    cnt_q <= '0;
                    if (idx_q == IDX_LAST) state_q <= STOP;
                end
                STOP: if (cnt_q == LAST) begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= IDLE;
                        if (!valid_q || out_if.ready) begin
                            data_q  <= sr_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        state_q     <= BREAK;
                        frame_err_q <= 1'b1;
                    end
                end
                BREAK: if (rxs) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.data      = data_q;
    assign out_if.valid     = valid_q;
    assign out_if.frame_err = frame_err_q;
    assign out_if.overrun   = overrun_q;
    assign out_if.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx at 8 and 436 clocks per bit
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    logic [7:0] e;
    int got_a = 0, vcyc_a = 0, fe_a = 0, ov_a = 0, fall_a = 0;
    int got_b = 0, fe_b = 0, ov_b = 0;
    logic pv_a = 1'b0;

    uart_rx_if a_if ();
    uart_rx_if b_if ();

    uart_rx #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .rx_i   (rx_a),
        .out_if (a_if)
    );

    uart_rx #(.CLKS_PER_BIT(436), .SYNC_STAGES(2)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .rx_i   (rx_b),
        .out_if (b_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] b, input logic stop, input int per);
        for (int i = 0; i < 10; i++) begin
            logic v;
            v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            if (which == 0) rx_a = v;
            else            rx_b = v;
            step(per);
        end
    endtask

    // monitor: pop the scoreboard on every accepted byte and count flag/valid activity
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_if.valid && a_if.ready) begin
                got_a++;
                tests++;
                e = (sb_a.size() != 0) ? sb_a.pop_front() : 8'hxx;
                assert (a_if.data === e) else begin
                    fails++;
                    $error("FAIL a_byte: observed %0h expected %0h", a_if.data, e);
                end
            end
            if (b_if.valid && b_if.ready) begin
                got_b++;
                tests++;
                e = (sb_b.size() != 0) ? sb_b.pop_front() : 8'hxx;
                assert (b_if.data === e) else begin
                    fails++;
                    $error("FAIL b_byte: observed %0h expected %0h", b_if.data, e);
                end
            end
            vcyc_a += int'(a_if.valid);
            fe_a   += int'(a_if.frame_err);
            ov_a   += int'(a_if.overrun);
            fe_b   += int'(b_if.frame_err);
            ov_b   += int'(b_if.overrun);
            if (pv_a && !a_if.valid) fall_a++;
        end
        pv_a = a_if.valid;
    end

    initial begin
        a_if.ready = 1'b1;
        b_if.ready = 1'b1;
        step(3);
        chk("rst_data", 32'(a_if.data), 0);
        chk("rst_valid", 32'(a_if.valid), 0);
        chk("rst_ferr", 32'(a_if.frame_err), 0);
        chk("rst_ovr", 32'(a_if.overrun), 0);
        chk("rst_busy", 32'(a_if.busy), 0);
        rst_n = 1'b1;
        step(5);

        sb_a.push_back(8'hA5);
        send(0, 8'hA5, 1'b1, 8);
        step(20);
        chk("a5_got", 32'(got_a), 1);
        chk("a5_vcyc", 32'(vcyc_a), 1);
        chk("a5_ferr", 32'(fe_a), 0);
        chk("a5_ovr", 32'(ov_a), 0);

        vcyc_a = 0;
        rx_a = 1'b0;
        step(2);
        rx_a = 1'b1;
        step(20);
        chk("glitch_busy", 32'(a_if.busy), 0);
        chk("glitch_vcyc", 32'(vcyc_a), 0);
        chk("glitch_ferr", 32'(fe_a), 0);
        sb_a.push_back(8'h3C);
        send(0, 8'h3C, 1'b1, 8);
        step(20);
        chk("3c_got", 32'(got_a), 2);

        vcyc_a = 0;
        send(0, 8'h55, 1'b0, 8);
        rx_a = 1'b0;
        step(40);
        chk("brk_busy", 32'(a_if.busy), 1);
        rx_a = 1'b1;
        step(20);
        chk("brk_ferr", 32'(fe_a), 1);
        chk("brk_vcyc", 32'(vcyc_a), 0);
        chk("brk_idle", 32'(a_if.busy), 0);
        sb_a.push_back(8'h81);
        send(0, 8'h81, 1'b1, 8);
        step(20);
        chk("81_got", 32'(got_a), 3);
        chk("81_ferr", 32'(fe_a), 1);

        a_if.ready = 1'b0;
        fall_a = 0;
        sb_a.push_back(8'h11);
        send(0, 8'h11, 1'b1, 8);
        send(0, 8'h22, 1'b1, 8);
        step(20);
        chk("ovr_valid", 32'(a_if.valid), 1);
        chk("ovr_data", 32'(a_if.data), 32'h11);
        chk("ovr_cnt", 32'(ov_a), 1);
        chk("ovr_nofall", 32'(fall_a), 0);
        a_if.ready = 1'b1;
        step(1);
        a_if.ready = 1'b0;
        step(2);
        chk("ovr_drop", 32'(a_if.valid), 0);
        chk("ovr_got", 32'(got_a), 4);
        chk("ovr_fall", 32'(fall_a), 1);

        a_if.ready = 1'b1;
        fe_a = 0;
        ov_a = 0;
        rx_a = 1'b0;
        step(8);
        for (int i = 0; i < 3; i++) begin
            rx_a = 1'b1;
            step(8);
        end
        chk("mid_busy", 32'(a_if.busy), 1);
        rst_n = 1'b0;
        rx_a = 1'b1;
        step(1);
        rst_n = 1'b1;
        chk("mrst_data", 32'(a_if.data), 0);
        chk("mrst_valid", 32'(a_if.valid), 0);
        chk("mrst_busy", 32'(a_if.busy), 0);
        chk("mrst_ferr", 32'(a_if.frame_err), 0);
        chk("mrst_ovr", 32'(a_if.overrun), 0);
        step(20);
        sb_a.push_back(8'h7E);
        send(0, 8'h7E, 1'b1, 8);
        step(20);
        chk("7e_got", 32'(got_a), 5);
        chk("7e_ferr", 32'(fe_a), 0);
        chk("7e_ovr", 32'(ov_a), 0);
        chk("a_sb_empty", 32'(sb_a.size()), 0);

        foreach (sb_b[i]) sb_b.delete(i);
        sb_b.push_back(8'h00);
        sb_b.push_back(8'hFF);
        sb_b.push_back(8'h5A);
        send(1, 8'h00, 1'b1, 445);
        send(1, 8'hFF, 1'b1, 445);
        send(1, 8'h5A, 1'b1, 445);
        step(50);
        chk("fast_got", 32'(got_b), 3);
        sb_b.push_back(8'h00);
        sb_b.push_back(8'hFF);
        sb_b.push_back(8'h5A);
        send(1, 8'h00, 1'b1, 427);
        send(1, 8'hFF, 1'b1, 427);
        send(1, 8'h5A, 1'b1, 427);
        step(50);
        chk("slow_got", 32'(got_b), 6);
        chk("b_ferr", 32'(fe_b), 0);
        chk("b_ovr", 32'(ov_b), 0);
        chk("b_sb_empty", 32'(sb_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
